// File: rtl/mips_pkg.sv
// Shared constants and endian encoding for the
// instruction fetch path.
package mips_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WORD_W_DEF = 32;

  typedef enum logic {
    ENDIAN_LE = 1'b0,
    ENDIAN_BE = 1'b1
  } endian_e;

  // Maps beat number to the slot it occupies in the word.
  function automatic int slot_of(
    input int      beat,
    input int      beats,
    input endian_e order
  );
    return (order == ENDIAN_BE) ? (beats - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/instr_word_assembler_if.sv
// Beat-in / word-out bundle between the instruction
// memory port and the decode stage.
interface instr_word_assembler_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WORD_W = WORD_W_DEF
);
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [WORD_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              busy;

  modport master (
    output mem_data, mem_valid, instr_ready,
    input  mem_ready, instr_out, instr_valid, busy
  );

  modport slave (
    input  mem_data, mem_valid, instr_ready,
    output mem_ready, instr_out, instr_valid, busy
  );
endinterface

// File: rtl/instr_hold_reg.sv
// One-entry output stage: holds a finished word
// until the consumer pops it.
module instr_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] q,
  output logic         valid
);

  // Valid flag: load wins over a same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (pop)   valid <= 1'b0;
  end

  // Data keeps its last value after a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                q <= '0;
    else if (load && !flush) q <= data;
  end

endmodule

// File: rtl/instr_word_assembler.sv
// Packs consecutive memory beats into one
// instruction word for the decode stage.
module instr_word_assembler
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  instr_word_assembler_if.slave  bus
);

  localparam int BEATS = WORD_W / DATA_W;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_d;
  logic              last;
  logic              accept;
  logic              hold_valid;
  int                slot;

  assign last   = (cnt == LAST);
  assign accept = bus.mem_valid && bus.mem_ready;

  // Only the closing beat waits for room in the
  // output stage; earlier beats overlap a stall.
  assign bus.mem_ready = !flush &&
    (!last || !hold_valid || bus.instr_ready);

  assign bus.busy        = (cnt != '0);
  assign bus.instr_valid = hold_valid;

  // Merge the incoming beat into its slot.
  always_comb begin
    slot  = slot_of(int'(cnt), BEATS,
                    endian_e'(BIG_ENDIAN));
    asm_d = asm_q;
    asm_d[slot*DATA_W +: DATA_W] = bus.mem_data;
  end

  // Beat counter and assembly register; stale
  // slots after a flush are overwritten later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (flush) begin
      cnt   <= '0;
    end else if (accept) begin
      asm_q <= asm_d;
      cnt   <= last ? '0 : cnt + 1'b1;
    end
  end

  instr_hold_reg #(
    .W (WORD_W)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .load  (accept && last),
    .pop   (bus.instr_ready),
    .data  (asm_d),
    .q     (bus.instr_out),
    .valid (hold_valid)
  );

endmodule

// File: tb/tb_instr_word_assembler.sv
// Bench for the instruction word assembler:
// vector table, directed corners, random vs model.
module tb_instr_word_assembler;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  instr_word_assembler_if #(.DATA_W(8),  .WORD_W(32)) bus_le();
  instr_word_assembler_if #(.DATA_W(8),  .WORD_W(32)) bus_be();
  instr_word_assembler_if #(.DATA_W(16), .WORD_W(32)) bus_16();

  assign bus_be.mem_data    = bus_le.mem_data;
  assign bus_be.mem_valid   = bus_le.mem_valid;
  assign bus_be.instr_ready = bus_le.instr_ready;

  instr_word_assembler #(
    .DATA_W(8), .WORD_W(32), .BIG_ENDIAN(1'b0)
  ) u_le (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_le)
  );

  instr_word_assembler #(
    .DATA_W(8), .WORD_W(32), .BIG_ENDIAN(1'b1)
  ) u_be (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_be)
  );

  instr_word_assembler #(
    .DATA_W(16), .WORD_W(32), .BIG_ENDIAN(1'b0)
  ) u_16 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_16)
  );

  typedef struct {
    logic        f;
    logic        mv;
    logic [7:0]  d;
    logic        ir;
    logic        er;
    logic        ev;
    logic [31:0] eo;
    logic        eb;
  } vec_t;

  vec_t vt[$];

  int checks = 0;
  int errors = 0;

  int unsigned q[$];
  logic        m_valid;
  logic [31:0] m_le;
  logic [31:0] m_be;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic v(
    input logic f, input logic mv,
    input logic [7:0] d, input logic ir,
    input logic er, input logic ev,
    input logic [31:0] eo, input logic eb
  );
    vec_t e;
    e.f = f; e.mv = mv; e.d = d; e.ir = ir;
    e.er = er; e.ev = ev; e.eo = eo; e.eb = eb;
    vt.push_back(e);
  endtask

  task automatic drive(
    input logic f, input logic mv,
    input logic [7:0] d, input logic ir
  );
    flush              = f;
    bus_le.mem_valid   = mv;
    bus_le.mem_data    = d;
    bus_le.instr_ready = ir;
  endtask

  task automatic beat(input logic [7:0] d, input logic ir);
    drive(1'b0, 1'b1, d, ir);
    @(posedge clk); #1;
  endtask

  initial begin
    logic er;
    logic popped;
    logic done;
    logic f, mv, ir;
    logic [7:0] d;

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    bus_16.mem_valid   = 1'b0;
    bus_16.mem_data    = '0;
    bus_16.instr_ready = 1'b0;

    // reset state while rst is held
    #2;
    check("rst_valid", 32'(bus_le.instr_valid), 32'd0);
    check("rst_busy",  32'(bus_le.busy),        32'd0);
    check("rst_out",   bus_le.instr_out,        32'd0);
    check("rst_ready", 32'(bus_le.mem_ready),   32'd1);
    check("rst_out16", bus_16.instr_out,        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // f mv data ir | ready valid out busy
    v(0,1,8'h78,1, 1,0,32'h0,0);
    v(0,1,8'h56,1, 1,0,32'h0,1);
    v(0,1,8'h34,1, 1,0,32'h0,1);
    v(0,1,8'h12,1, 1,0,32'h0,1);
    v(0,0,8'h00,1, 1,1,32'h12345678,0);
    v(0,0,8'h00,1, 1,0,32'h12345678,0);
    v(0,1,8'h01,1, 1,0,32'h12345678,0);
    v(0,1,8'h02,1, 1,0,32'h12345678,1);
    v(0,1,8'h03,1, 1,0,32'h12345678,1);
    v(0,1,8'h04,1, 1,0,32'h12345678,1);
    v(0,1,8'h05,1, 1,1,32'h04030201,0);
    v(0,1,8'h06,1, 1,0,32'h04030201,1);
    v(0,1,8'h07,1, 1,0,32'h04030201,1);
    v(0,1,8'h08,1, 1,0,32'h04030201,1);
    v(0,0,8'h00,1, 1,1,32'h08070605,0);
    v(0,0,8'h00,0, 1,0,32'h08070605,0);
    v(0,1,8'ha1,0, 1,0,32'h08070605,0);
    v(0,1,8'ha2,0, 1,0,32'h08070605,1);
    v(0,1,8'ha3,0, 1,0,32'h08070605,1);
    v(0,1,8'ha4,0, 1,0,32'h08070605,1);
    v(0,1,8'hb1,0, 1,1,32'ha4a3a2a1,0);
    v(0,1,8'hb2,0, 1,1,32'ha4a3a2a1,1);
    v(0,1,8'hb3,0, 1,1,32'ha4a3a2a1,1);
    v(0,1,8'hb4,0, 0,1,32'ha4a3a2a1,1);
    v(0,1,8'hb4,0, 0,1,32'ha4a3a2a1,1);
    v(0,1,8'hb4,1, 1,1,32'ha4a3a2a1,1);
    v(0,0,8'h00,0, 1,1,32'hb4b3b2b1,0);
    v(0,0,8'h00,1, 1,1,32'hb4b3b2b1,0);
    v(0,0,8'h00,1, 1,0,32'hb4b3b2b1,0);
    v(0,1,8'haa,1, 1,0,32'hb4b3b2b1,0);
    v(0,1,8'hbb,1, 1,0,32'hb4b3b2b1,1);
    v(1,1,8'hcc,1, 0,0,32'hb4b3b2b1,1);
    v(0,1,8'h11,1, 1,0,32'hb4b3b2b1,0);
    v(0,1,8'h22,1, 1,0,32'hb4b3b2b1,1);
    v(0,1,8'h33,1, 1,0,32'hb4b3b2b1,1);
    v(0,1,8'h44,1, 1,0,32'hb4b3b2b1,1);
    v(0,0,8'h00,1, 1,1,32'h44332211,0);
    v(0,1,8'h01,0, 1,0,32'h44332211,0);
    v(0,1,8'h02,0, 1,0,32'h44332211,1);
    v(0,1,8'h03,0, 1,0,32'h44332211,1);
    v(0,1,8'h04,0, 1,0,32'h44332211,1);
    v(0,0,8'h00,0, 1,1,32'h04030201,0);
    v(1,0,8'h00,0, 0,1,32'h04030201,0);
    v(0,0,8'h00,0, 1,0,32'h04030201,0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].f, vt[i].mv, vt[i].d, vt[i].ir);
      @(negedge clk);
      check($sformatf("v%0d_ready", i),
            32'(bus_le.mem_ready), 32'(vt[i].er));
      check($sformatf("v%0d_valid", i),
            32'(bus_le.instr_valid), 32'(vt[i].ev));
      check($sformatf("v%0d_out", i),
            bus_le.instr_out, vt[i].eo);
      check($sformatf("v%0d_busy", i),
            32'(bus_le.busy), 32'(vt[i].eb));
      if (i == 4)
        check("be_word1", bus_be.instr_out, 32'h78563412);
      if (i == 10)
        check("be_word2", bus_be.instr_out, 32'h01020304);
      @(posedge clk); #1;
    end

    // async reset with a held word and a partial one
    beat(8'hef, 1'b0);
    beat(8'hbe, 1'b0);
    beat(8'had, 1'b0);
    beat(8'hde, 1'b0);
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 32'(bus_le.instr_valid), 32'd1);
    check("pre_rst_busy",  32'(bus_le.busy),        32'd1);
    check("pre_rst_out",   bus_le.instr_out, 32'hdeadbeef);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus_le.instr_valid), 32'd0);
    check("arst_busy",  32'(bus_le.busy),        32'd0);
    check("arst_out",   bus_le.instr_out,        32'd0);
    check("arst_ready", 32'(bus_le.mem_ready),   32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    beat(8'h11, 1'b1);
    beat(8'h22, 1'b1);
    beat(8'h33, 1'b1);
    beat(8'h44, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("post_rst_valid", 32'(bus_le.instr_valid), 32'd1);
    check("post_rst_le", bus_le.instr_out, 32'h44332211);
    check("post_rst_be", bus_be.instr_out, 32'h11223344);
    @(posedge clk); #1;

    // 16-bit beats
    bus_16.instr_ready = 1'b1;
    bus_16.mem_valid   = 1'b1;
    bus_16.mem_data    = 16'h5678;
    @(negedge clk);
    check("w16_ready", 32'(bus_16.mem_ready), 32'd1);
    @(posedge clk); #1;
    bus_16.mem_data = 16'h1234;
    @(negedge clk);
    check("w16_busy", 32'(bus_16.busy), 32'd1);
    @(posedge clk); #1;
    bus_16.mem_valid = 1'b0;
    @(negedge clk);
    check("w16_valid", 32'(bus_16.instr_valid), 32'd1);
    check("w16_out",   bus_16.instr_out, 32'h12345678);
    @(posedge clk); #1;

    // clean start for the random phase
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    q.delete();
    m_valid = 1'b0;
    m_le    = 32'h44332211;
    m_be    = 32'h11223344;

    for (int n = 0; n < 500; n++) begin
      f  = ($urandom_range(0, 19) == 0);
      mv = ($urandom_range(0, 9) < 7);
      ir = ($urandom_range(0, 9) < 6);
      d  = 8'($urandom);
      drive(f, mv, d, ir);
      er = !f && (q.size() != 3 || !m_valid || ir);
      @(negedge clk);
      check("rnd_ready", 32'(bus_le.mem_ready), 32'(er));
      check("rnd_valid", 32'(bus_le.instr_valid),
            32'(m_valid));
      check("rnd_busy", 32'(bus_le.busy),
            32'(q.size() != 0));
      check("rnd_le", bus_le.instr_out, m_le);
      check("rnd_be", bus_be.instr_out, m_be);
      check("rnd_be_valid", 32'(bus_be.instr_valid),
            32'(m_valid));
      if (f) begin
        q.delete();
        m_valid = 1'b0;
      end else begin
        popped = m_valid && ir;
        done   = 1'b0;
        if (mv && er) q.push_back(32'(d));
        if (q.size() == 4) begin
          m_le = 32'd0;
          m_be = 32'd0;
          for (int k = 0; k < 4; k++) begin
            m_le = m_le | (q[k] << (8 * k));
            m_be = m_be | (q[k] << (8 * (3 - k)));
          end
          q.delete();
          done = 1'b1;
        end
        if (done)        m_valid = 1'b1;
        else if (popped) m_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
